// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the Pong rule/score blocks.
//   ref_state_t     - match state of the referee
//   DEF_*           - default field limits, serve delay and match length
//   SCORE_MAX       - point count at which score counters saturate
//   sat_inc()       - saturating increment for a score counter
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SERVE,
      PLAY,
      SCORE,
      OVER
   } ref_state_t;

   localparam int unsigned DEF_X_W          = 10;
   localparam int unsigned DEF_LEFT_LIMIT   = 8;
   localparam int unsigned DEF_RIGHT_LIMIT  = 631;
   localparam int unsigned DEF_SERVE_FRAMES = 60;
   localparam int unsigned DEF_WIN_SCORE    = 11;

   localparam int unsigned SCORE_W   = 7;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 7'd99;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v >= SCORE_MAX) ? v : v + 7'd1;
   endfunction

endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: rising-edge detector.
//   clk   - clock
//   reset - asynchronous active-high reset (clears the history flop)
//   level - level input, synchronous to clk
//   pulse - high while level is 1 and was 0 on the previous clock
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/game_referee.sv
// game_referee: Pong match rule engine.
//   clk, reset          - clock, asynchronous active-high reset
//   start               - start button level (edge-detected here)
//   frame_tick          - one-cycle strobe per video frame
//   ball_x              - ball X position, valid with frame_tick
//   player_right_scores - one-cycle pulse, right player scored
//   player_left_scores  - one-cycle pulse, left player scored
//   score_clear         - one-cycle pulse at match start
//   ball_run            - ball motion enable
//   ball_center         - hold ball at field centre
//   serve_left          - next serve goes toward the left player
//   game_over           - match finished
// All outputs are flops updated together with the state register.
module game_referee
   import pong_pkg::*;
#(
   parameter int unsigned X_W          = DEF_X_W,
   parameter int unsigned LEFT_LIMIT   = DEF_LEFT_LIMIT,
   parameter int unsigned RIGHT_LIMIT  = DEF_RIGHT_LIMIT,
   parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
   parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           frame_tick,
   input  logic [X_W-1:0] ball_x,
   output logic           player_right_scores,
   output logic           player_left_scores,
   output logic           score_clear,
   output logic           ball_run,
   output logic           ball_center,
   output logic           serve_left,
   output logic           game_over
);

   localparam int unsigned CNT_W = ($clog2(SERVE_FRAMES + 1) > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
   localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
   localparam logic [X_W-1:0]   LEFT_X     = X_W'(LEFT_LIMIT);
   localparam logic [X_W-1:0]   RIGHT_X    = X_W'(RIGHT_LIMIT);

   ref_state_t         state;
   logic [CNT_W-1:0]   serve_cnt;
   logic [SCORE_W-1:0] score_r;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_now;
   logic               start_pulse;

   edge_pulse u_start_edge (
      .clk   (clk),
      .reset (reset),
      .level (start),
      .pulse (start_pulse)
   );

   // In SCORE, serve_left was just set toward the conceding side, so it
   // also identifies whose counter was bumped.
   assign score_now = serve_left ? score_r : score_l;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         serve_cnt           <= '0;
         score_r             <= '0;
         score_l             <= '0;
         player_right_scores <= 1'b0;
         player_left_scores  <= 1'b0;
         score_clear         <= 1'b0;
         ball_run            <= 1'b0;
         ball_center         <= 1'b1;
         serve_left          <= 1'b0;
         game_over           <= 1'b0;
      end else begin
         // Strobes default low; set for exactly one cycle below.
         player_right_scores <= 1'b0;
         player_left_scores  <= 1'b0;
         score_clear         <= 1'b0;

         unique case (state)
            IDLE, OVER: begin
               if (start_pulse) begin
                  state       <= SERVE;
                  score_clear <= 1'b1;
                  score_r     <= '0;
                  score_l     <= '0;
                  serve_left  <= 1'b0;
                  serve_cnt   <= SERVE_LOAD;
                  game_over   <= 1'b0;
                  ball_center <= 1'b1;
                  ball_run    <= 1'b0;
               end
            end

            SERVE: begin
               if (serve_cnt == '0) begin
                  state       <= PLAY;
                  ball_run    <= 1'b1;
                  ball_center <= 1'b0;
               end else if (frame_tick) begin
                  serve_cnt <= serve_cnt - CNT_W'(1);
               end
            end

            PLAY: begin
               if (frame_tick) begin
                  // Left test first: it wins if the limits overlap.
                  if (ball_x <= LEFT_X) begin
                     state               <= SCORE;
                     player_right_scores <= 1'b1;
                     score_r             <= sat_inc(score_r);
                     serve_left          <= 1'b1;
                     ball_run            <= 1'b0;
                     ball_center         <= 1'b1;
                  end else if (ball_x >= RIGHT_X) begin
                     state              <= SCORE;
                     player_left_scores <= 1'b1;
                     score_l            <= sat_inc(score_l);
                     serve_left         <= 1'b0;
                     ball_run           <= 1'b0;
                     ball_center        <= 1'b1;
                  end
               end
            end

            SCORE: begin
               if (WIN_SCORE != 0 && 32'(score_now) == WIN_SCORE) begin
                  state     <= OVER;
                  game_over <= 1'b1;
               end else begin
                  state     <= SERVE;
                  serve_cnt <= SERVE_LOAD;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: directed plus random stimulus for game_referee, checked
// every cycle against a behavioural model of the match rules.
module tb_game_referee;

   localparam int unsigned XW = 10;
   localparam int unsigned LL = 8;
   localparam int unsigned RL = 631;
   localparam int unsigned SF = 3;
   localparam int unsigned WS = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          frame_tick;
   logic [XW-1:0] ball_x;
   logic          prs, pls, sc, br, bc, sl, go;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   game_referee #(
      .X_W          (XW),
      .LEFT_LIMIT   (LL),
      .RIGHT_LIMIT  (RL),
      .SERVE_FRAMES (SF),
      .WIN_SCORE    (WS)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start),
      .frame_tick          (frame_tick),
      .ball_x              (ball_x),
      .player_right_scores (prs),
      .player_left_scores  (pls),
      .score_clear         (sc),
      .ball_run            (br),
      .ball_center         (bc),
      .serve_left          (sl),
      .game_over           (go)
   );

   // Model: a match is "active" between start and game end; within it the
   // ball is either waiting out the serve (m_wait frames left) or live.
   bit m_prev_start, m_active, m_live, m_done, m_sl, m_pr, m_pl, m_clr;
   int m_wait, m_cnt_r, m_cnt_l;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function void model_reset();
      m_prev_start = 0; m_active = 0; m_live = 0; m_done = 0;
      m_sl = 0; m_pr = 0; m_pl = 0; m_clr = 0;
      m_wait = 0; m_cnt_r = 0; m_cnt_l = 0;
   endfunction

   function void model_step();
      bit rise, pr, pl, clr;
      int who;
      rise = (start === 1'b1) && !m_prev_start;
      m_prev_start = (start === 1'b1);
      pr = 0; pl = 0; clr = 0;
      if (!m_active) begin
         if (rise) begin
            clr = 1; m_cnt_r = 0; m_cnt_l = 0; m_sl = 0;
            m_active = 1; m_done = 0; m_live = 0; m_wait = SF;
         end
      end else if (m_pr || m_pl) begin
         who = m_pr ? m_cnt_r : m_cnt_l;
         if (WS != 0 && who == WS) begin
            m_active = 0; m_done = 1;
         end else begin
            m_wait = SF;
         end
      end else if (!m_live) begin
         if (m_wait == 0) m_live = 1;
         else if (frame_tick === 1'b1) m_wait = m_wait - 1;
      end else if (frame_tick === 1'b1) begin
         if (ball_x <= LL) begin
            pr = 1; m_cnt_r = (m_cnt_r >= 99) ? 99 : m_cnt_r + 1; m_sl = 1; m_live = 0;
         end else if (ball_x >= RL) begin
            pl = 1; m_cnt_l = (m_cnt_l >= 99) ? 99 : m_cnt_l + 1; m_sl = 0; m_live = 0;
         end
      end
      m_pr = pr; m_pl = pl; m_clr = clr;
   endfunction

   task automatic check_all();
      chk("score_clear", sc, m_clr);
      chk("right_scores", prs, m_pr);
      chk("left_scores", pls, m_pl);
      chk("ball_run", br, m_active && m_live);
      chk("ball_center", bc, !(m_active && m_live));
      chk("serve_left", sl, m_sl);
      chk("game_over", go, m_done);
      chk("score_r", dut.score_r, m_cnt_r);
      chk("score_l", dut.score_l, m_cnt_l);
   endtask

   task automatic step();
      @(posedge clk);
      if (reset === 1'b1) model_reset();
      else model_step();
      #1;
      check_all();
   endtask

   // Tick frames with a centred ball until the rally is live (bounded).
   task automatic to_play();
      ball_x = 10'd320;
      for (int i = 0; i < 50; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
         if (br === 1'b1) break;
      end
      chk("reach_play", br, 1);
   endtask

   task automatic exit_ball(input logic [XW-1:0] x);
      ball_x = x; frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
   endtask

   initial begin
      int n;
      int v;
      logic [XW-1:0] edges [4];
      edges[0] = 10'd8; edges[1] = 10'd9; edges[2] = 10'd630; edges[3] = 10'd631;

      reset = 1'b1; start = 1'b0; frame_tick = 1'b0; ball_x = 10'd320;
      model_reset();
      #1;
      check_all();
      step(); step();
      reset = 1'b0;
      step();

      // Held start: exactly one match start.
      start = 1'b1; n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (sc === 1'b1) n++;
      end
      chk("clear_once", n, 1);

      // Serve delay: ball_run rises one clock after the third tick.
      for (int i = 0; i < 3; i++) begin
         chk("serve_no_run", br, 0);
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
      chk("run_after_serve", br, 1);

      // Left exit.
      ball_x = 10'd5; frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      chk("right_pulse", prs, 1);
      step();
      chk("right_pulse_end", prs, 0);
      chk("serve_left_set", sl, 1);
      chk("score_r_one", dut.score_r, 1);

      // Right exit: no score until the tick arrives.
      to_play();
      ball_x = 10'd700; frame_tick = 1'b0; n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (pls === 1'b1 || prs === 1'b1) n++;
      end
      chk("no_score_without_tick", n, 0);
      frame_tick = 1'b1; step();
      frame_tick = 1'b0;
      chk("left_pulse", pls, 1);
      chk("serve_left_clr", sl, 0);
      step();

      // Third point ends the match (right reaches 2).
      to_play();
      exit_ball(10'd5);
      step();
      chk("game_over_set", go, 1);

      // Restart, then two left exits end a fresh match.
      start = 1'b0; step();
      start = 1'b1; step();
      chk("restart_clear", sc, 1);
      chk("restart_score_r", dut.score_r, 0);
      to_play(); exit_ball(10'd5);
      to_play(); exit_ball(10'd5);
      step();
      chk("game_over_two_left", go, 1);

      // Random play.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(63) == 0) start = ~start;
         frame_tick = ($urandom_range(3) == 0);
         v = $urandom_range(99);
         if (v < 5) ball_x = edges[$urandom_range(3)];
         else if (v < 12) ball_x = XW'($urandom_range(8));
         else if (v < 20) ball_x = XW'($urandom_range(1023, 631));
         else ball_x = XW'($urandom_range(630, 9));
         step();
      end

      // Reset during a rally with an exit pending on the same cycle.
      start = 1'b0; frame_tick = 1'b0;
      reset = 1'b1; step();
      reset = 1'b0; step();
      start = 1'b1; step();
      to_play();
      ball_x = 10'd5; frame_tick = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      step();
      frame_tick = 1'b0; reset = 1'b0;
      step(); step();
      chk("idle_after_reset", bc, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
